// File: rtl/pc_dbg_ctrl.sv
// Debug sequencer: host commands arm a PC breakpoint in pc_debug,
// halt/resume the core and run N-instruction single-steps.
// Ports: clk, reset_b | cmd_valid/ready/op/arg | mv_PC, lock_rq,
// timer_done | pc_timer, pc_init_addr, dbg_halt, dbg_state,
// hit_pulse, hit_pc, cmd_err.
module pc_dbg_ctrl #(
  parameter int PC_W   = 11,
  parameter int STEP_W = 8
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [PC_W-1:0] cmd_arg,
  input  logic [PC_W-1:0] mv_PC,
  input  logic            lock_rq,
  input  logic            timer_done,
  output logic [1:0]      pc_timer,
  output logic [PC_W-1:0] pc_init_addr,
  output logic            dbg_halt,
  output logic [2:0]      dbg_state,
  output logic            hit_pulse,
  output logic [PC_W-1:0] hit_pc,
  output logic            cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARMED  = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET_BP = 3'd1;
  localparam logic [2:0] OP_RUN_BP = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_HALT   = 3'd4;
  localparam logic [2:0] OP_RESUME = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  state_t              state, nxt;
  logic [PC_W-1:0]     bp_reg, bp_nxt;
  logic [STEP_W-1:0]   step_cnt, cnt_nxt;
  logic [PC_W-1:0]     hp_nxt;
  logic                err_nxt, hit_nxt;
  logic                accept, hit;
  logic [STEP_W-1:0]   step_arg;

  // In ARMED a pending hit blocks commands so the hit wins.
  assign cmd_ready = (state == IDLE) || (state == HALTED) ||
                     ((state == ARMED) && !timer_done);
  assign accept       = cmd_valid && cmd_ready;
  assign hit          = (state == ARMED) && timer_done;
  assign step_arg     = cmd_arg[STEP_W-1:0];
  assign pc_init_addr = bp_reg;
  assign dbg_state    = state;

  always_comb begin
    nxt     = state;
    bp_nxt  = bp_reg;
    cnt_nxt = step_cnt;
    hp_nxt  = hit_pc;
    err_nxt = 1'b0;
    hit_nxt = 1'b0;
    if (hit) begin
      nxt     = HALTED;
      hit_nxt = 1'b1;
      hp_nxt  = mv_PC;
    end else if (state == LOAD) begin
      nxt = ARMED;
    end else if (state == STEP) begin
      if (!lock_rq) begin
        cnt_nxt = step_cnt - 1'b1;
        if (step_cnt == STEP_W'(1)) nxt = HALTED;
      end
    end else if (accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_SET_BP: begin
          // all-ones can never match, so refuse it
          if (&cmd_arg) err_nxt = 1'b1;
          else          bp_nxt  = cmd_arg;
        end
        OP_RUN_BP: begin
          if (state == ARMED) err_nxt = 1'b1;
          else                nxt     = LOAD;
        end
        OP_STEP: begin
          if (state != HALTED || step_arg == '0) begin
            err_nxt = 1'b1;
          end else begin
            cnt_nxt = step_arg;
            nxt     = STEP;
          end
        end
        OP_HALT:   nxt = HALTED;
        OP_RESUME: if (state == HALTED) nxt = IDLE;
        OP_CLEAR:  nxt = IDLE;
        OP_RSVD:   err_nxt = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= IDLE;
      bp_reg    <= '0;
      step_cnt  <= '0;
      hit_pc    <= '0;
      hit_pulse <= 1'b0;
      cmd_err   <= 1'b0;
      pc_timer  <= 2'b00;
      dbg_halt  <= 1'b0;
    end else begin
      state     <= nxt;
      bp_reg    <= bp_nxt;
      step_cnt  <= cnt_nxt;
      hit_pc    <= hp_nxt;
      hit_pulse <= hit_nxt;
      cmd_err   <= err_nxt;
      dbg_halt  <= (nxt == HALTED);
      unique case (1'b1)
        (nxt == LOAD):  pc_timer <= 2'b11;
        (nxt == ARMED): pc_timer <= 2'b10;
        default:        pc_timer <= 2'b00;
      endcase
    end
  end

endmodule
